// File: rtl/jk_counter_sequencer.sv
// rtl/jk_counter_sequencer.sv - run/hold/done sequencer around a JK-style synchronous counter
// Optional prescaler on the advance strobe is enabled by defining COUNTER_PRESCALE_EN.
module jk_counter_sequencer #(
  parameter int WIDTH   = 5,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             mode_wrap_i,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             start_acc;
  logic             advance;
  logic             at_limit;
  logic             tc;
  logic             clr;
  logic             inc;

  assign start_acc = ((state_q == IDLE) || (state_q == DONE)) && start_i && !stop_i;
  assign at_limit  = (count_q == limit_q);

`ifdef COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q;
  logic               presc_hit;

  assign presc_hit = (pcnt_q == presc_q);
  assign advance   = (state_q == RUN) && !pause_i && !stop_i && presc_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (start_acc) begin
      presc_q <= presc_i;
      pcnt_q  <= '0;
    end else if ((state_q == RUN) && !pause_i) begin
      pcnt_q <= presc_hit ? '0 : pcnt_q + 1'b1;
    end
  end
`else
  assign advance = (state_q == RUN) && !pause_i && !stop_i;
`endif

  assign tc  = advance && at_limit;
  assign clr = start_acc || (tc && mode_q);
  assign inc = advance && !at_limit;

  // Each bit is a JK flop: clear drives J=0/K=1, counting drives J=K=carry-in.
  always_comb begin
    logic carry;
    logic j;
    logic k;
    count_d = count_q;
    carry   = inc;
    for (int i = 0; i < WIDTH; i++) begin
      if (clr) begin
        j = 1'b0;
        k = 1'b1;
      end else begin
        j = carry;
        k = carry;
      end
      count_d[i] = (j & ~count_q[i]) | (~k & count_q[i]);
      carry      = carry & count_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (start_acc) begin
        limit_q <= limit_i;
        mode_q  <= mode_wrap_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_acc) state_d = RUN;
      RUN: begin
        if (stop_i)             state_d = IDLE;
        else if (pause_i)       state_d = HOLD;
        else if (tc && !mode_q) state_d = DONE;
      end
      HOLD: begin
        if (stop_i)        state_d = IDLE;
        else if (!pause_i) state_d = RUN;
      end
      DONE: begin
        if (stop_i)         state_d = IDLE;
        else if (start_acc) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == RUN) || (state_q == HOLD);
    done_o  = (state_q == DONE);
    state_o = state_q;
    count_o = count_q;
    tc_o    = tc;
  end

endmodule
